// File: rtl/board_generator.sv
// Minesweeper board builder: clears the board memory, scatters NUM_MINES mines
// from a Galois LFSR (never on the first-click cell) and accumulates neighbour counts.
module board_generator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int COLS          = 16,
    parameter int ROWS          = 16,
    parameter int NUM_MINES     = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              seed,
    input  logic [ADDRESS_WIDTH-1:0] safe_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [15:0]              CAND_MASK   = 16'((32'd1 << CW) - 32'd1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL   = ADDRESS_WIDTH'(CELLS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_A       = ADDRESS_WIDTH'(1);
    localparam logic [16:0]              MINES_TOTAL = 17'(NUM_MINES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_PICK  = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_NB    = 3'd4;
    localparam logic [2:0] S_NBW   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]               state_q, state_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [ADDRESS_WIDTH-1:0] safe_q, safe_d;
    logic [ADDRESS_WIDTH-1:0] cand_q, cand_d;
    logic [ADDRESS_WIDTH-1:0] row_q, row_d;
    logic [ADDRESS_WIDTH-1:0] col_q, col_d;
    logic [ADDRESS_WIDTH-1:0] clr_q, clr_d;
    logic [2:0]               nb_q, nb_d;
    logic [16:0]              mines_q, mines_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;

    logic [15:0]              lfsr_step;
    logic [15:0]              cand;
    logic                     cand_ok;
    int                       dr, dc, nb_r, nb_c;
    logic                     nb_ok;
    logic [ADDRESS_WIDTH-1:0] nb_addr;
    logic [2:0]               after_nb;
    logic [4:0]               cell_rd;
    logic                     unused_rd;

    assign cell_rd   = mem_dataOut[4:0];
    assign unused_rd = ^mem_dataOut;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand      = lfsr_step & CAND_MASK;
    assign cand_ok   = (int'(cand) < CELLS) && (ADDRESS_WIDTH'(cand) != safe_q);
    assign after_nb  = (mines_q == MINES_TOTAL) ? S_FIN : S_PICK;

    // Neighbour offsets walked in fixed raster order; off-board ones are skipped.
    always_comb begin
        dr = 0;
        dc = 0;
        case (nb_q)
            3'd0:    begin dr = -1; dc = -1; end
            3'd1:    begin dr = -1; dc =  0; end
            3'd2:    begin dr = -1; dc =  1; end
            3'd3:    begin dr =  0; dc = -1; end
            3'd4:    begin dr =  0; dc =  1; end
            3'd5:    begin dr =  1; dc = -1; end
            3'd6:    begin dr =  1; dc =  0; end
            default: begin dr =  1; dc =  1; end
        endcase
        nb_r    = int'(row_q) + dr;
        nb_c    = int'(col_q) + dc;
        nb_ok   = (nb_r >= 0) && (nb_r < ROWS) && (nb_c >= 0) && (nb_c < COLS);
        nb_addr = ADDRESS_WIDTH'(nb_r * COLS + nb_c);
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        safe_d  = safe_q;
        cand_d  = cand_q;
        row_d   = row_q;
        col_d   = col_q;
        clr_d   = clr_q;
        nb_d    = nb_q;
        mines_d = mines_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 16'h0000) ? 16'hACE1 : seed;
                    safe_d  = safe_addr;
                    busy_d  = 1'b1;
                    wen_d   = 1'b1;
                    addr_d  = '0;
                    clr_d   = ONE_A;
                    mines_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wen_d  = 1'b1;
                addr_d = clr_q;
                if (clr_q == LAST_CELL) state_d = S_PICK;
                else                    clr_d   = clr_q + ONE_A;
            end
            S_PICK: begin
                lfsr_d = lfsr_step;
                if (cand_ok) begin
                    cand_d  = ADDRESS_WIDTH'(cand);
                    row_d   = ADDRESS_WIDTH'(int'(cand) / COLS);
                    col_d   = ADDRESS_WIDTH'(int'(cand) % COLS);
                    addr_d  = ADDRESS_WIDTH'(cand);
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (cell_rd[4]) begin
                    state_d = S_PICK;
                end else begin
                    wen_d   = 1'b1;
                    addr_d  = cand_q;
                    din_d   = DATA_WIDTH'({1'b1, cell_rd[3:0]});
                    mines_d = mines_q + 17'd1;
                    nb_d    = '0;
                    state_d = S_NB;
                end
            end
            S_NB: begin
                if (nb_ok) begin
                    addr_d  = nb_addr;
                    state_d = S_NBW;
                end else begin
                    nb_d    = nb_q + 3'd1;
                    state_d = (nb_q == 3'd7) ? after_nb : S_NB;
                end
            end
            S_NBW: begin
                wen_d   = 1'b1;
                din_d   = DATA_WIDTH'({cell_rd[4], cell_rd[3:0] + 4'd1});
                nb_d    = nb_q + 3'd1;
                state_d = (nb_q == 3'd7) ? after_nb : S_NB;
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            safe_q  <= '0;
            cand_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            clr_q   <= '0;
            nb_q    <= '0;
            mines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            safe_q  <= safe_d;
            cand_q  <= cand_d;
            row_q   <= row_d;
            col_q   <= col_d;
            clr_q   <= clr_d;
            nb_q    <= nb_d;
            mines_q <= mines_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_wEn    = wen_q;
    assign mem_addr   = addr_q;
    assign mem_dataIn = din_q;
endmodule

// File: tb/tb_board_generator.sv
// Bench for board_generator: three configurations (16x16/40, 4x4/15, 3x2/1), each
// with its own board memory, checked against a behavioural board model.
module tb_board_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst_v, start_v, busy_v, done_v, wen_v;
    logic [2:0][15:0]  seed_v;
    logic [2:0][11:0]  safe_v, addr_v;
    logic [2:0][31:0]  din_v, dout_v;
    logic [31:0]       mem [3][256];
    logic [31:0]       exp_board [256];
    logic [31:0]       snap [256];
    int                n_checks = 0;
    int                n_fail   = 0;

    board_generator u_big (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .seed(seed_v[0]), .safe_addr(safe_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .mem_wEn(wen_v[0]), .mem_addr(addr_v[0]),
        .mem_dataIn(din_v[0]), .mem_dataOut(dout_v[0]));

    board_generator #(.COLS(4), .ROWS(4), .NUM_MINES(15)) u_full (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .seed(seed_v[1]), .safe_addr(safe_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .mem_wEn(wen_v[1]), .mem_addr(addr_v[1]),
        .mem_dataIn(din_v[1]), .mem_dataOut(dout_v[1]));

    board_generator #(.COLS(3), .ROWS(2), .NUM_MINES(1)) u_tiny (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .seed(seed_v[2]), .safe_addr(safe_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .mem_wEn(wen_v[2]), .mem_addr(addr_v[2]),
        .mem_dataIn(din_v[2]), .mem_dataOut(dout_v[2]));

    // Memory samples the registered request on the falling edge; read data is ready by the next rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            dout_v[k] <= mem[k][addr_v[k][7:0]];
            if (wen_v[k] === 1'b1) mem[k][addr_v[k][7:0]] <= din_v[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int cols, input int rows, input int nm,
                               input logic [15:0] sd, input int safe);
        int n, cw, placed, c, cnt;
        logic [15:0] l;
        bit mine [256];
        n = cols * rows;
        cw = 0;
        while ((1 << cw) < n) cw++;
        l = (sd == 16'h0000) ? 16'hACE1 : sd;
        placed = 0;
        for (int i = 0; i < 256; i++) begin
            mine[i] = 1'b0;
            exp_board[i] = 32'd0;
        end
        for (int it = 0; it < 1000000 && placed < nm; it++) begin
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
            c = int'(l) % (1 << cw);
            if (c < n && c != safe && !mine[c]) begin
                mine[c] = 1'b1;
                placed++;
            end
        end
        for (int r = 0; r < rows; r++) begin
            for (int q = 0; q < cols; q++) begin
                cnt = 0;
                for (int a = -1; a <= 1; a++)
                    for (int b = -1; b <= 1; b++)
                        if ((a != 0 || b != 0) && r + a >= 0 && r + a < rows &&
                            q + b >= 0 && q + b < cols && mine[(r + a) * cols + q + b])
                            cnt++;
                exp_board[r * cols + q] = {27'd0, mine[r * cols + q], 4'(cnt)};
            end
        end
    endtask

    task automatic cmp_board(input int k, input int n, input string tag);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), mem[k][i], exp_board[i]);
    endtask

    function automatic int count_mines(input int k, input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (mem[k][i][4] === 1'b1) m++;
        return m;
    endfunction

    task automatic run(input int k, input logic [15:0] sd, input int sf, input bit chk_clear,
                       input int extra_at, output int cyc);
        int pulses;
        @(negedge clk);
        seed_v[k]  = sd;
        safe_v[k]  = 12'(sf);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        check("busy_after_start", busy_v[k], 1);
        cyc = 0;
        while (cyc < 30000 && done_v[k] !== 1'b1) begin
            if (chk_clear && cyc < 256)
                check($sformatf("clear_write[%0d]", cyc),
                      {wen_v[k], addr_v[k], din_v[k]}, {1'b1, 12'(cyc), 32'd0});
            if (cyc == extra_at) begin
                start_v[k] = 1'b1;
                seed_v[k]  = 16'h5A5A;
            end else begin
                start_v[k] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_v[k] = 1'b0;
        check("done_seen", done_v[k], 1);
        check("busy_low_at_done", busy_v[k], 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[k] !== 1'b0) pulses++;
        end
        check("done_single_cycle", pulses, 0);
    endtask

    initial begin
        int cyc, cyc0, cyc1, sf;
        logic [15:0] sd;
        bit flag;
        rst_v   = '1;
        start_v = '0;
        seed_v  = '0;
        safe_v  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state[%0d]", k),
                  {busy_v[k], done_v[k], wen_v[k], addr_v[k], din_v[k]}, 64'd0);
        rst_v = '0;

        // 4x4 board, 15 mines: every cell except the safe one is a mine.
        run(1, 16'h1234, 5, 1'b0, -1, cyc);
        check("full_cell5", mem[1][5], 32'h08);
        check("full_cell0", mem[1][0], 32'h12);
        check("full_cell15", mem[1][15], 32'h13);
        check("full_cell1", mem[1][1], 32'h14);
        for (int i = 0; i < 16; i++)
            if (i != 5) check($sformatf("full_mine[%0d]", i), mem[1][i][4], 1);
        build_model(4, 4, 15, 16'h1234, 5);
        cmp_board(1, 16, "full_model");
        repeat (2) begin
            sd = 16'($urandom);
            sf = int'($urandom_range(0, 15));
            run(1, sd, sf, 1'b0, -1, cyc);
            build_model(4, 4, 15, sd, sf);
            cmp_board(1, 16, "full_rand");
        end

        // 3x2 board, mine at column 2 row 0: no wrap into addr 3.
        run(2, 16'h0004, 0, 1'b0, -1, cyc);
        check("tiny_mine2", mem[2][2], 32'h10);
        check("tiny_nb1", mem[2][1], 32'h01);
        check("tiny_nb4", mem[2][4], 32'h01);
        check("tiny_nb5", mem[2][5], 32'h01);
        check("tiny_cell0", mem[2][0], 32'h00);
        check("tiny_nowrap3", mem[2][3], 32'h00);
        repeat (3) begin
            sd = 16'($urandom);
            sf = int'($urandom_range(0, 5));
            run(2, sd, sf, 1'b0, -1, cyc);
            build_model(3, 2, 1, sd, sf);
            cmp_board(2, 6, "tiny_rand");
        end

        // Default board, seed 1, safe cell 0, with the clear sweep watched.
        run(0, 16'h0001, 0, 1'b1, -1, cyc);
        check("big_mine_total", count_mines(0, 256), 40);
        check("big_safe_clear", mem[0][0][4], 0);
        build_model(16, 16, 40, 16'h0001, 0);
        cmp_board(0, 256, "big_model");

        // Seed 0 must behave exactly as seed ACE1.
        sf = int'($urandom_range(0, 255));
        run(0, 16'h0000, sf, 1'b0, -1, cyc0);
        for (int i = 0; i < 256; i++) snap[i] = mem[0][i];
        run(0, 16'hACE1, sf, 1'b0, -1, cyc1);
        check("seed0_cycles", cyc0, cyc1);
        for (int i = 0; i < 256; i++) check($sformatf("seed0_image[%0d]", i), snap[i], mem[0][i]);
        build_model(16, 16, 40, 16'hACE1, sf);
        cmp_board(0, 256, "ace1_model");

        // Starts while busy (during clear, then during placement) are ignored.
        sd = 16'($urandom);
        sf = int'($urandom_range(0, 255));
        run(0, sd, sf, 1'b0, 100, cyc);
        check("busy_start_mines", count_mines(0, 256), 40);
        build_model(16, 16, 40, sd, sf);
        cmp_board(0, 256, "busy_start_a");
        run(0, sd ^ 16'h0F0F, sf, 1'b0, 300, cyc);
        build_model(16, 16, 40, sd ^ 16'h0F0F, sf);
        cmp_board(0, 256, "busy_start_b");

        // Reset 30 cycles into placement abandons the run.
        @(negedge clk);
        seed_v[0]  = 16'h3C3C;
        safe_v[0]  = 12'd12;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (256 + 30) @(negedge clk);
        check("busy_before_rst", busy_v[0], 1);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("after_rst", {busy_v[0], wen_v[0], done_v[0], addr_v[0], din_v[0]}, 64'd0);
        flag = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || wen_v[0] !== 1'b0 || busy_v[0] !== 1'b0) flag = 1'b1;
        end
        check("quiet_after_rst", flag, 0);
        run(0, 16'h3C3C, 12, 1'b1, -1, cyc);
        build_model(16, 16, 40, 16'h3C3C, 12);
        cmp_board(0, 256, "after_rst_model");

        // Start coinciding with reset is dropped.
        @(negedge clk);
        rst_v[2]   = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2]   = 1'b0;
        start_v[2] = 1'b0;
        check("rst_start_busy", busy_v[2], 0);
        @(negedge clk);
        check("rst_start_idle", {busy_v[2], wen_v[2]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
